simple_lsu: RTL and testbench

- Load/store unit sitting directly upstream of the byte-addressed simple_memory.
- Accepts one load or store request at a time from the execute stage over a valid/ready handshake.
- Drives the memory's read address, write address, write data and byte strobes; waits out the memory's 1-cycle registered read; returns sign- or zero-extended load data.
- Flags out-of-range and reserved-size accesses as faults without touching memory.

---
 rtl/lsu_pkg.sv | 65 ++++++
 rtl/simple_lsu_load_extend.sv | 28 ++
 rtl/simple_lsu.sv | 192 +++++++++++++++++++
 tb/tb_simple_lsu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// simple_lsu shared definitions: size encodings, FSM states,
// byte-strobe constants and small size helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LD_ISSUE = 3'd1,
        S_LD_DATA  = 3'd2,
        S_ST_ISSUE = 3'd3,
        S_RESP     = 3'd4
    } state_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // Number of bytes touched by an access; reserved size touches none.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        n = 3'd0;
        unique case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Byte-strobe pattern for a store of the given size.
    function automatic logic [3:0] size_strb(input logic [1:0] sz);
        logic [3:0] s;
        s = 4'b0000;
        unique case (1'b1)
            (sz == SZ_BYTE): s = STRB_B;
            (sz == SZ_HALF): s = STRB_H;
            (sz == SZ_WORD): s = STRB_W;
            default:         s = 4'b0000;
        endcase
        return s;
    endfunction

    // Natural-alignment check: halves on even, words on 4-byte boundaries.
    function automatic logic is_misaligned(
        input logic [1:0] sz,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        unique case (sz)
            SZ_HALF: m = lo[0];
            SZ_WORD: m = |lo;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/simple_lsu_load_extend.sv
// simple_lsu load extender: selects the low byte/half/word of the
// raw memory word and sign- or zero-extends it to 32 bits.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic sign_b;
    logic sign_h;

    assign sign_b = ~i_unsigned & i_raw[7];
    assign sign_h = ~i_unsigned & i_raw[15];

    // Pick the lane by access size and fill the upper bits.
    always_comb begin
        o_data = i_raw;
        unique case (i_size)
            SZ_BYTE: o_data = {{24{sign_b}}, i_raw[7:0]};
            SZ_HALF: o_data = {{16{sign_h}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/simple_lsu.sv
// simple_lsu: single-outstanding load/store unit in front of the
// byte-addressed simple_memory. Optional LSU_MISALIGN_TRAP_EN traps misaligned half/word.
module simple_lsu
    import lsu_pkg::*;
#(
    parameter logic [31:0] pMemBytes = 32'd176
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwReqValid,
    output logic        owReqReady,
    input  logic        iwReqWrite,
    input  logic [1:0]  iwReqSize,
    input  logic        iwReqUnsigned,
    input  logic [31:0] iwReqAddr,
    input  logic [31:0] iwReqWdata,
    output logic        orRspValid,
    input  logic        iwRspReady,
    output logic [31:0] orRspData,
    output logic        orRspFault,
    output logic [31:0] orMemReadAddr,
    output logic [31:0] orMemWriteAddr,
    output logic [31:0] orMemWriteData,
    output logic [3:0]  orMemWstrb,
    input  logic [31:0] iwMemReadData
);

    state_e      state_q;
    state_e      state_d;

    logic [31:0] rd_addr_q;
    logic [31:0] rd_addr_d;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_addr_d;
    logic [31:0] wr_data_q;
    logic [31:0] wr_data_d;
    logic [3:0]  wstrb_q;
    logic [3:0]  wstrb_d;
    logic        rsp_valid_q;
    logic        rsp_valid_d;
    logic [31:0] rsp_data_q;
    logic [31:0] rsp_data_d;
    logic        rsp_fault_q;
    logic        rsp_fault_d;
    logic [1:0]  size_q;
    logic [1:0]  size_d;
    logic        uns_q;
    logic        uns_d;

    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        oob;
    logic        rsvd;
    logic        misal;
    logic        acc_fault;
    logic [31:0] ext_data;

    // Bound check in 33 bits so addresses near 2^32 cannot wrap legal.
    always_comb begin
        nbytes   = size_bytes(iwReqSize);
        end_addr = {1'b0, iwReqAddr} + {30'd0, nbytes};
        oob      = end_addr > {1'b0, pMemBytes};
        rsvd     = (iwReqSize == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        misal    = is_misaligned(iwReqSize, iwReqAddr[1:0]);
`else
        misal    = 1'b0;
`endif
        acc_fault = rsvd | oob | misal;
    end

    lsu_load_extend u_ext (
        .i_raw      (iwMemReadData),
        .i_size     (size_q),
        .i_unsigned (uns_q),
        .o_data     (ext_data)
    );

    // State register and all datapath flops.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
        end
    end

    // Next-state: one access in flight, faults skip memory entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (iwReqValid) begin
                    if (acc_fault) begin
                        state_d = S_RESP;
                    end else if (iwReqWrite) begin
                        state_d = S_ST_ISSUE;
                    end else begin
                        state_d = S_LD_ISSUE;
                    end
                end
            end
            S_LD_ISSUE: state_d = S_LD_DATA;
            S_LD_DATA:  state_d = S_RESP;
            S_ST_ISSUE: state_d = S_RESP;
            S_RESP: begin
                if (iwRspReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs; the strobe defaults low so it lives one cycle.
    always_comb begin
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wstrb_d     = 4'b0000;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        size_d      = size_q;
        uns_d       = uns_q;
        unique case (state_q)
            S_IDLE: begin
                if (iwReqValid) begin
                    size_d      = iwReqSize;
                    uns_d       = iwReqUnsigned;
                    rsp_data_d  = '0;
                    rsp_fault_d = acc_fault;
                    if (acc_fault) begin
                        rsp_valid_d = 1'b1;
                    end else if (iwReqWrite) begin
                        wr_addr_d = iwReqAddr;
                        wr_data_d = iwReqWdata;
                        wstrb_d   = size_strb(iwReqSize);
                    end else begin
                        rd_addr_d = iwReqAddr;
                    end
                end
            end
            S_LD_DATA: begin
                rsp_data_d  = ext_data;
                rsp_fault_d = 1'b0;
                rsp_valid_d = 1'b1;
            end
            S_ST_ISSUE: begin
                rsp_data_d  = '0;
                rsp_fault_d = 1'b0;
                rsp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (iwRspReady) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign owReqReady     = (state_q == S_IDLE);
    assign orRspValid     = rsp_valid_q;
    assign orRspData      = rsp_data_q;
    assign orRspFault     = rsp_fault_q;
    assign orMemReadAddr  = rd_addr_q;
    assign orMemWriteAddr = wr_addr_q;
    assign orMemWriteData = wr_data_q;
    assign orMemWstrb     = wstrb_q;

endmodule

// File: tb/tb_simple_lsu.sv
// tb_simple_lsu: directed test of simple_lsu against a small
// byte-addressed memory model with a 1-cycle registered read.
module tb_simple_lsu;

    localparam int MEMB = 176;

    logic        iwClk;
    logic        iwnRst;
    logic        iwReqValid;
    logic        owReqReady;
    logic        iwReqWrite;
    logic [1:0]  iwReqSize;
    logic        iwReqUnsigned;
    logic [31:0] iwReqAddr;
    logic [31:0] iwReqWdata;
    logic        orRspValid;
    logic        iwRspReady;
    logic [31:0] orRspData;
    logic        orRspFault;
    logic [31:0] orMemReadAddr;
    logic [31:0] orMemWriteAddr;
    logic [31:0] orMemWriteData;
    logic [3:0]  orMemWstrb;
    logic [31:0] iwMemReadData;

    int n_cmp;
    int n_bad;

    simple_lsu #(.pMemBytes(32'd176)) dut (
        .iwClk          (iwClk),
        .iwnRst         (iwnRst),
        .iwReqValid     (iwReqValid),
        .owReqReady     (owReqReady),
        .iwReqWrite     (iwReqWrite),
        .iwReqSize      (iwReqSize),
        .iwReqUnsigned  (iwReqUnsigned),
        .iwReqAddr      (iwReqAddr),
        .iwReqWdata     (iwReqWdata),
        .orRspValid     (orRspValid),
        .iwRspReady     (iwRspReady),
        .orRspData      (orRspData),
        .orRspFault     (orRspFault),
        .orMemReadAddr  (orMemReadAddr),
        .orMemWriteAddr (orMemWriteAddr),
        .orMemWriteData (orMemWriteData),
        .orMemWstrb     (orMemWstrb),
        .iwMemReadData  (iwMemReadData)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    // Memory model: byte k resets to value k; registered read.
    logic [7:0] mem [MEMB];
    always @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            for (int i = 0; i < MEMB; i++) mem[i] <= 8'(i);
            iwMemReadData <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                longint wa;
                longint ra;
                wa = longint'(orMemWriteAddr) + b;
                ra = longint'(orMemReadAddr) + b;
                if (orMemWstrb[b] && wa < MEMB)
                    mem[int'(wa)] <= orMemWriteData[8*b +: 8];
                iwMemReadData[8*b +: 8] <= (ra < MEMB) ? mem[int'(ra)] : 8'h00;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic run_req(
        input  logic        wr,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          hold,
        output logic [31:0] data,
        output logic        flt,
        output int          lat,
        output int          scnt,
        output logic [3:0]  slast
    );
        scnt  = 0;
        slast = 4'b0000;
        data  = '0;
        flt   = 1'b0;
        iwReqWrite    = wr;
        iwReqSize     = sz;
        iwReqUnsigned = uns;
        iwReqAddr     = addr;
        iwReqWdata    = wdata;
        iwReqValid    = 1'b1;
        @(posedge iwClk);
        #1;
        iwReqValid = 1'b0;
        lat = 1;
        if (orMemWstrb != 4'b0000) begin
            scnt++;
            slast = orMemWstrb;
        end
        while (!orRspValid && lat < 8) begin
            @(posedge iwClk);
            #1;
            lat++;
            if (orMemWstrb != 4'b0000) begin
                scnt++;
                slast = orMemWstrb;
            end
        end
        if (!orRspValid) begin
            check("rsp_timeout", 32'(orRspValid), 32'd1);
        end else begin
            data = orRspData;
            flt  = orRspFault;
            for (int k = 0; k < hold; k++) begin
                @(posedge iwClk);
                #1;
                check("hold_valid", 32'(orRspValid), 32'd1);
                check("hold_data", orRspData, data);
                check("hold_ready", 32'(owReqReady), 32'd0);
            end
            iwRspReady = 1'b1;
            @(posedge iwClk);
            #1;
            iwRspReady = 1'b0;
            check("rsp_clear", 32'(orRspValid), 32'd0);
        end
    endtask

    logic [31:0] d;
    logic        f;
    int          lat;
    int          sc;
    logic [3:0]  sl;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        iwnRst        = 1'b0;
        iwReqValid    = 1'b0;
        iwReqWrite    = 1'b0;
        iwReqSize     = 2'b00;
        iwReqUnsigned = 1'b0;
        iwReqAddr     = '0;
        iwReqWdata    = '0;
        iwRspReady    = 1'b0;
        repeat (2) @(posedge iwClk);
        #1;
        check("rst_ready", 32'(owReqReady), 32'd1);
        check("rst_valid", 32'(orRspValid), 32'd0);
        check("rst_data", orRspData, 32'h0);
        check("rst_wstrb", 32'(orMemWstrb), 32'h0);
        check("rst_raddr", orMemReadAddr, 32'h0);
        @(negedge iwClk);
        iwnRst = 1'b1;
        @(posedge iwClk);
        #1;

        // Store word, then load it back.
        run_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, d, f, lat, sc, sl);
        check("stw_lat", 32'(lat), 32'd2);
        check("stw_fault", 32'(f), 32'd0);
        check("stw_data", d, 32'h0);
        check("stw_scnt", 32'(sc), 32'd1);
        check("stw_strb", 32'(sl), 32'hF);
        check("stw_waddr", orMemWriteAddr, 32'h10);
        run_req(0, 2'b10, 0, 32'h10, 32'h0, 0, d, f, lat, sc, sl);
        check("ldw_lat", 32'(lat), 32'd3);
        check("ldw_data", d, 32'hDEADBEEF);
        check("ldw_scnt", 32'(sc), 32'd0);

        // Byte store then signed/unsigned byte loads and neighbours.
        run_req(1, 2'b00, 0, 32'h21, 32'h12345680, 0, d, f, lat, sc, sl);
        check("stb_strb", 32'(sl), 32'h1);
        check("stb_scnt", 32'(sc), 32'd1);
        run_req(0, 2'b00, 0, 32'h21, 32'h0, 0, d, f, lat, sc, sl);
        check("ldb_s", d, 32'hFFFFFF80);
        run_req(0, 2'b00, 1, 32'h21, 32'h0, 0, d, f, lat, sc, sl);
        check("ldb_u", d, 32'h00000080);
        run_req(0, 2'b10, 0, 32'h20, 32'h0, 0, d, f, lat, sc, sl);
        check("ldb_nbr", d, 32'h23228020);

        // Half store then signed/unsigned half loads.
        run_req(1, 2'b01, 0, 32'h30, 32'hAAAA8001, 0, d, f, lat, sc, sl);
        check("sth_strb", 32'(sl), 32'h3);
        run_req(0, 2'b01, 0, 32'h30, 32'h0, 0, d, f, lat, sc, sl);
        check("ldh_s", d, 32'hFFFF8001);
        run_req(0, 2'b01, 1, 32'h30, 32'h0, 0, d, f, lat, sc, sl);
        check("ldh_u", d, 32'h00008001);

        // Bounds: last legal word, one past, store past, reserved, wrap.
        run_req(0, 2'b10, 0, 32'd172, 32'h0, 0, d, f, lat, sc, sl);
        check("ld172_fault", 32'(f), 32'd0);
        check("ld172_data", d, 32'hAFAEADAC);
        run_req(0, 2'b10, 0, 32'd173, 32'h0, 0, d, f, lat, sc, sl);
        check("ld173_fault", 32'(f), 32'd1);
        check("ld173_lat", 32'(lat), 32'd1);
        check("ld173_data", d, 32'h0);
        run_req(1, 2'b10, 0, 32'd173, 32'h55555555, 0, d, f, lat, sc, sl);
        check("st173_fault", 32'(f), 32'd1);
        check("st173_scnt", 32'(sc), 32'd0);
        run_req(0, 2'b10, 0, 32'd172, 32'h0, 0, d, f, lat, sc, sl);
        check("ld172_again", d, 32'hAFAEADAC);
        run_req(0, 2'b11, 0, 32'h0, 32'h0, 0, d, f, lat, sc, sl);
        check("rsvd_fault", 32'(f), 32'd1);
        check("rsvd_lat", 32'(lat), 32'd1);
        run_req(0, 2'b10, 0, 32'hFFFFFFFE, 32'h0, 0, d, f, lat, sc, sl);
        check("wrap_fault", 32'(f), 32'd1);

        // Misaligned accesses.
        run_req(0, 2'b10, 0, 32'h11, 32'h0, 0, d, f, lat, sc, sl);
`ifdef LSU_MISALIGN_TRAP_EN
        check("misw_fault", 32'(f), 32'd1);
        check("misw_data", d, 32'h0);
`else
        check("misw_fault", 32'(f), 32'd0);
        check("misw_data", d, 32'h14DEADBE);
`endif
        run_req(0, 2'b01, 0, 32'h31, 32'h0, 0, d, f, lat, sc, sl);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mish_fault", 32'(f), 32'd1);
`else
        check("mish_data", d, 32'h00003280);
`endif

        // Back-pressure: response held for 5 cycles.
        run_req(0, 2'b10, 0, 32'h10, 32'h0, 5, d, f, lat, sc, sl);
        check("hold_first", d, 32'hDEADBEEF);

        // Reset during ST_ISSUE kills the strobe asynchronously.
        iwReqWrite = 1'b1;
        iwReqSize  = 2'b10;
        iwReqAddr  = 32'h40;
        iwReqWdata = 32'hCAFEF00D;
        iwReqValid = 1'b1;
        @(posedge iwClk);
        #1;
        iwReqValid = 1'b0;
        check("rst_pre_strb", 32'(orMemWstrb), 32'hF);
        iwnRst = 1'b0;
        #1;
        check("rst_mid_strb", 32'(orMemWstrb), 32'h0);
        check("rst_mid_ready", 32'(owReqReady), 32'd1);
        check("rst_mid_valid", 32'(orRspValid), 32'd0);
        @(negedge iwClk);
        iwnRst = 1'b1;
        @(posedge iwClk);
        #1;
        run_req(0, 2'b10, 0, 32'h40, 32'h0, 0, d, f, lat, sc, sl);
        check("post_rst_ld", d, 32'h43424140);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
